dmem_wait_responder: RTL and testbench
======================================

Name: dmem_wait_responder

Overview:
- Data-memory responder for the core's MEM-stage port: dmem_addr / dmem_wdata / dmem_byte_en / dmem_wr_en / dmem_rd_en in, dmem_rdata out.
- Adds a fixed, programmable access latency and drives the MEM stall signal. This lets the pipeline's mem_stall path be exercised against slow memory.
- Holds a word-organised backing store with per-byte write enables.
- Sits beside the memory controller as the data-side target.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 4096, backing-store size in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0001_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
- LATENCY, 2, cycles from request acceptance to dmem_ready; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_addr  in  XLEN  byte address; bits [1:0] ignored.
- dmem_wdata  in  XLEN  write data, already lane-aligned by the MEM stage.
- dmem_byte_en  in  4  byte-lane write enables.
- dmem_wr_en  in  1  write request.
- dmem_rd_en  in  1  read request.
- dmem_rdata  out  XLEN  registered read data.
- dmem_ready  out  1  one-cycle completion pulse.
- dmem_stall  out  1  holds the MEM stage while a request is outstanding.
- dmem_err  out  1  one-cycle error pulse, aligned with dmem_ready.

Behaviour:
- Request present: req = dmem_rd_en | dmem_wr_en.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With req, capture addr, wdata, byte_en, the op, and the range/conflict checks.
  - Load cnt = LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT: cnt decrements each cycle; when cnt==1, next state is RESP.
- RESP: lasts one cycle, then returns to IDLE unconditionally. IDLE samples inputs again on the following cycle.
- Latency: a request first seen in cycle T gives dmem_ready=1 in cycle T+LATENCY, exactly.
- dmem_stall is combinational:
  - 1 when state==IDLE and req, or when state==WAIT.
  - 0 in RESP, and 0 in IDLE with no req.
  - The core therefore advances on the RESP cycle.
- dmem_ready = (state==RESP). dmem_err pulses in RESP only.
- Reads:
  - Array read on the clock edge entering RESP.
  - dmem_rdata updates at that edge and holds until the next read completes.
  - Writes do not change dmem_rdata.
- Writes:
  - Commit on the clock edge leaving RESP, to lanes where byte_en[i]=1.
  - byte_en==0 is a legal no-op write.
- Read-after-write:
  - Back-to-back accesses are separated by at least one IDLE cycle, so the next request observes committed data.
- Out-of-range (addr outside BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1):
  - Write dropped; read returns 32'h0; dmem_err=1; latency unchanged.
- rd_en and wr_en both high: treated as a write, with dmem_err=1.
- Inputs changing or deasserting during WAIT are ignored. The captured transaction always completes, and writes commit.
- Index arithmetic: word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check. Offset wrap-around is caught by the range check.
- Reset, including mid-operation:
  - state=IDLE, cnt=0, dmem_rdata=0, dmem_ready=0, dmem_err=0.
  - A pending write is dropped.
  - Backing-store contents are not reset.
- With reset high, dmem_stall=0 regardless of req.

Decomposition:
- riscv_pkg gains:
  - dmem_resp_state_t enum (IDLE, WAIT, RESP).
  - DMEM_LATENCY_DEFAULT = 2.
  - DMEM_BASE_ADDR = 32'h0001_0000.
- One sub-module, byte_lane_ram:
  - DEPTH_WORDS x 32 array, 4-bit byte write enable, synchronous read, no reset on contents.
  - dmem_wait_responder holds the FSM, counter, capture registers and checks.

Test Plan:
- Read latency: LATENCY=2, preload word 0 = 32'hDEAD_BEEF, rd_en at addr 32'h0001_0000 in cycle T:
  - dmem_stall=1 in T and T+1.
  - dmem_ready=1, dmem_stall=0, dmem_rdata=32'hDEAD_BEEF in T+2.
  - Idle in T+3.
- Byte write: word 1 = 32'h1122_3344, write addr 32'h0001_0004, wdata 32'hAABB_CCDD, byte_en 4'b0101, then a read of the same word = 32'h11BB_33DD, err=0.
- Latency sweep: LATENCY=1 and LATENCY=7 produce ready exactly 1 and 7 cycles after the request; stall is high for exactly LATENCY cycles.
- Out-of-range: read at 32'h0000_FFFC returns rdata 0 with err=1 in the ready cycle; write at BASE_ADDR+4*DEPTH_WORDS leaves memory unchanged and err=1.
- Simultaneous rd_en and wr_en at word 2 with wdata 32'h5A5A_5A5A and byte_en 4'hF: the write commits, err=1, a later read returns 32'h5A5A_5A5A.
- Reset mid-write: write issued, reset asserted in the WAIT cycle. Outputs go to 0 immediately, the target word is unchanged, and the next read completes normally after LATENCY cycles.

Source files
------------

// File: rtl/dmem_wait_responder_pkg.sv
// Shared types and defaults for the data-memory wait responder.
//   dmem_resp_state_t    : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_LATENCY_DEFAULT : default request-to-ready latency in cycles
//   DMEM_BASE_ADDR       : default byte address of backing-store word 0
package dmem_wait_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_resp_state_t;

  localparam int unsigned DMEM_LATENCY_DEFAULT = 2;
  localparam logic [31:0] DMEM_BASE_ADDR       = 32'h0001_0000;

endpackage

// File: rtl/dmem_wait_responder_byte_lane_ram.sv
// Word-organised backing store with per-byte write enables.
//   clk     : clock, rising edge
//   addr    : word index
//   wdata   : write data, lane aligned
//   byte_en : per-lane write enables
//   wr_en   : write strobe
//   rd_en   : read strobe; rdata updates only when set (synchronous read)
//   rdata   : registered read data
// Contents are not reset.
module byte_lane_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    byte_en,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// MEM-stage data-memory responder with a fixed access latency and stall.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   dmem_addr    : byte address (bits [1:0] ignored)
//   dmem_wdata   : lane-aligned write data
//   dmem_byte_en : byte-lane write enables
//   dmem_wr_en   : write request
//   dmem_rd_en   : read request
//   dmem_rdata   : registered read data, held until the next read completes
//   dmem_ready   : one-cycle completion pulse
//   dmem_stall   : holds the MEM stage while a request is outstanding
//   dmem_err     : one-cycle error pulse aligned with dmem_ready
module dmem_wait_responder
  import dmem_wait_responder_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(DMEM_BASE_ADDR),
  parameter int unsigned     LATENCY     = DMEM_LATENCY_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [3:0]      dmem_byte_en,
  input  logic            dmem_wr_en,
  input  logic            dmem_rd_en,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ready,
  output logic            dmem_stall,
  output logic            dmem_err
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS * 4);

  dmem_resp_state_t state, next_state;

  logic [3:0]      cnt;
  logic [AW-1:0]   cap_idx;
  logic [XLEN-1:0] cap_wdata;
  logic [3:0]      cap_be;
  logic            cap_wr;
  logic            cap_ok;
  logic            cap_err;
  logic            rdata_zero;

  logic            req;
  logic [XLEN-1:0] offset;
  logic            in_range;
  logic [AW-1:0]   live_idx;

  logic [AW-1:0]   ram_addr;
  logic            ram_rd_en;
  logic            ram_wr_en;
  logic [31:0]     ram_rdata;
  logic            rd_op;
  logic            op_ok;
  logic            entering_resp;

  assign req = dmem_rd_en | dmem_wr_en;

  // Base is span-aligned and span is a multiple of 4, so comparing the raw
  // byte offset gives the same answer as comparing the word-aligned one;
  // a negative offset wraps to a huge value and fails the compare.
  assign offset   = dmem_addr - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN;
  assign live_idx = offset[AW+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cap_wr    <= 1'b0;
      cap_ok    <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt       <= 4'(LATENCY - 1);
            cap_idx   <= live_idx;
            cap_wdata <= dmem_wdata;
            cap_be    <= dmem_byte_en;
            cap_wr    <= dmem_wr_en;
            cap_ok    <= in_range;
            cap_err   <= ~in_range | (dmem_rd_en & dmem_wr_en);
          end
        end
        WAIT:    cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // With LATENCY==1 the read launches straight from IDLE, so the array must
  // be addressed from the live request rather than the capture registers.
  always_comb begin
    if (state == IDLE) begin
      ram_addr = live_idx;
      rd_op    = dmem_rd_en & ~dmem_wr_en;
      op_ok    = in_range;
    end else begin
      ram_addr = cap_idx;
      rd_op    = ~cap_wr;
      op_ok    = cap_ok;
    end
  end

  assign entering_resp = (next_state == RESP) && (state != RESP);
  assign ram_rd_en     = entering_resp & rd_op & op_ok;
  assign ram_wr_en     = (state == RESP) & cap_wr & cap_ok;

  // Out-of-range reads and reset force zero without touching the array's
  // output register, which has no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_zero <= 1'b1;
    else if (entering_resp && rd_op) rdata_zero <= ~op_ok;
  end

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .addr    (ram_addr),
    .wdata   (cap_wdata),
    .byte_en (cap_be),
    .wr_en   (ram_wr_en),
    .rd_en   (ram_rd_en),
    .rdata   (ram_rdata)
  );

  assign dmem_rdata = rdata_zero ? '0 : ram_rdata;
  assign dmem_ready = (state == RESP);
  assign dmem_err   = (state == RESP) & cap_err;
  assign dmem_stall = ~reset & (((state == IDLE) & req) | (state == WAIT));

endmodule

// File: tb/tb_dmem_wait_responder.sv
module tb_dmem_wait_responder;
  import dmem_wait_responder_pkg::*;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = DMEM_BASE_ADDR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  be     [3];
  logic        wr     [3];
  logic        rd     [3];
  logic [31:0] rdata  [3];
  logic        ready  [3];
  logic        stall  [3];
  logic        err    [3];

  int unsigned lat [3] = '{2, 1, 7};

  logic [31:0] mem_m   [3][DEPTH];
  logic [31:0] last_rd [3];

  int total = 0;
  int bad   = 0;

  dmem_wait_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
    .dmem_byte_en(be[0]), .dmem_wr_en(wr[0]), .dmem_rd_en(rd[0]),
    .dmem_rdata(rdata[0]), .dmem_ready(ready[0]), .dmem_stall(stall[0]), .dmem_err(err[0]));

  dmem_wait_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
    .dmem_byte_en(be[1]), .dmem_wr_en(wr[1]), .dmem_rd_en(rd[1]),
    .dmem_rdata(rdata[1]), .dmem_ready(ready[1]), .dmem_stall(stall[1]), .dmem_err(err[1]));

  dmem_wait_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(7)) u_l7 (
    .clk(clk), .reset(rst[2]), .dmem_addr(addr[2]), .dmem_wdata(wdata[2]),
    .dmem_byte_en(be[2]), .dmem_wr_en(wr[2]), .dmem_rd_en(rd[2]),
    .dmem_rdata(rdata[2]), .dmem_ready(ready[2]), .dmem_stall(stall[2]), .dmem_err(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One complete transaction on DUT d, checked cycle by cycle against the
  // model: stall for exactly lat cycles, ready/err/rdata on cycle lat, then
  // one idle cycle with everything quiet and rdata held.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input bit scramble);
    longint al;
    bit     inr;
    int     idx;
    bit     exp_err;
    al  = longint'({a[31:2], 2'b00});
    inr = (al >= longint'(BASE)) && (al < longint'(BASE) + 4 * longint'(DEPTH));
    idx = inr ? int'((al - longint'(BASE)) / 4) : 0;
    exp_err = !inr || (r && w);
    if (!w) last_rd[d] = inr ? mem_m[d][idx] : 32'h0;

    @(posedge clk); #1;
    addr[d] = a; wdata[d] = wd; be[d] = b; rd[d] = r; wr[d] = w;
    for (int k = 0; k <= int'(lat[d]); k++) begin
      @(negedge clk);
      if (k == int'(lat[d])) begin
        chk($sformatf("ready d%0d", d), 32'(ready[d]), 32'd1);
        chk($sformatf("stall_resp d%0d", d), 32'(stall[d]), 32'd0);
        chk($sformatf("err d%0d", d), 32'(err[d]), 32'(exp_err));
        chk($sformatf("rdata d%0d a=%h", d, a), rdata[d], last_rd[d]);
      end else begin
        chk($sformatf("stall_wait d%0d k%0d", d, k), 32'(stall[d]), 32'd1);
        chk($sformatf("ready_early d%0d k%0d", d, k), 32'(ready[d]), 32'd0);
      end
      if (scramble && k >= 1 && k < int'(lat[d])) begin
        addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
        rd[d] = 1'($urandom); wr[d] = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (w && inr) mem_m[d][idx] = merge(mem_m[d][idx], wd, b);
    @(negedge clk);
    chk($sformatf("idle_stall d%0d", d), 32'(stall[d]), 32'd0);
    chk($sformatf("idle_ready d%0d", d), 32'(ready[d]), 32'd0);
    chk($sformatf("idle_err d%0d", d), 32'(err[d]), 32'd0);
    chk($sformatf("rdata_hold d%0d", d), rdata[d], last_rd[d]);
  endtask

  function automatic int unsigned pick_word(input int unsigned j);
    return (j < 16) ? j : (4072 + j);
  endfunction

  function automatic logic [31:0] pick_oor(input int unsigned j);
    logic [31:0] t [6];
    t = '{BASE - 32'd4, BASE - 32'd1, BASE + 32'd16384, BASE + 32'd16387,
          32'h0000_0000, 32'hFFFF_FFFC};
    return t[j];
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; addr[d] = BASE; wdata[d] = '0; be[d] = '0;
      rd[d] = 1'b1; wr[d] = 1'b0; last_rd[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_stall d%0d", d), 32'(stall[d]), 32'd0);
      chk($sformatf("rst_ready d%0d", d), 32'(ready[d]), 32'd0);
      chk($sformatf("rst_err d%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_rdata d%0d", d), rdata[d], 32'd0);
      rd[d] = 1'b0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Give every tracked word a known value.
    for (int d = 0; d < 3; d++)
      for (int unsigned j = 0; j < 24; j++)
        access(d, 1'b0, 1'b1, BASE + 32'(4 * pick_word(j)), $urandom, 4'hF, 1'b0);

    // Directed cases on the LATENCY=2 instance.
    access(0, 1'b0, 1'b1, BASE, 32'hDEAD_BEEF, 4'hF, 1'b0);
    access(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, 1'b0);
    chk("read_deadbeef", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b0, 1'b1, BASE + 32'd4, 32'h1122_3344, 4'hF, 1'b0);
    access(0, 1'b0, 1'b1, BASE + 32'd4, 32'hAABB_CCDD, 4'b0101, 1'b0);
    access(0, 1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'h0, 1'b0);
    chk("byte_merge", rdata[0], 32'h11BB_33DD);
    access(0, 1'b0, 1'b1, BASE + 32'd8, 32'h0BAD_0BAD, 4'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 1'b0);
    chk("oor_read_zero", rdata[0], 32'h0);
    access(0, 1'b0, 1'b1, BASE + 32'd16384, 32'h1234_5678, 4'hF, 1'b0);
    access(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, 1'b0);
    chk("oor_write_no_alias", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b1, BASE + 32'd8, 32'h5A5A_5A5A, 4'hF, 1'b0);
    access(0, 1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0, 1'b0);
    chk("both_is_write", rdata[0], 32'h5A5A_5A5A);

    // Reset during the WAIT cycle of a write.
    access(0, 1'b0, 1'b1, BASE + 32'd12, 32'h3333_3333, 4'hF, 1'b0);
    @(posedge clk); #1;
    addr[0] = BASE + 32'd12; wdata[0] = 32'hCAFE_F00D; be[0] = 4'hF; wr[0] = 1'b1;
    @(negedge clk);
    chk("mid_stall_idle", 32'(stall[0]), 32'd1);
    @(negedge clk);
    chk("mid_stall_wait", 32'(stall[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall[0]), 32'd0);
    chk("mid_rst_ready", 32'(ready[0]), 32'd0);
    chk("mid_rst_err", 32'(err[0]), 32'd0);
    chk("mid_rst_rdata", rdata[0], 32'd0);
    wr[0] = 1'b0;
    last_rd[0] = 32'h0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    access(0, 1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0, 1'b0);
    chk("mid_rst_word_kept", rdata[0], 32'h3333_3333);

    // Randomised traffic on all three latencies.
    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < 3; d++) begin
        logic [31:0] a;
        int unsigned op;
        if ($urandom_range(0, 9) < 2) a = pick_oor($urandom_range(0, 5));
        else a = BASE + 32'(4 * pick_word($urandom_range(0, 23))) + 32'($urandom_range(0, 3));
        op = $urandom_range(0, 3);
        access(d, (op == 0 || op == 2 || op == 3), (op == 1 || op == 2), a,
               $urandom, 4'($urandom), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
